// File: rtl/psk_symbol_modulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psk_symbol_modulator: AXI-Stream symbols to held BPSK/QPSK/8PSK I/Q samples |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module psk_symbol_modulator #(
    parameter int OUT_W = 12,
    parameter int SPS   = 16,
    parameter int AMP   = 1024
) (
    input  logic                    clk_16M384,
    input  logic                    rst_n_16M384,
    input  logic [7:0]              data_tdata,
    input  logic                    data_tvalid,
    output logic                    data_tready,
    input  logic                    data_tlast,
    input  logic [1:0]              data_tuser,
    input  logic                    diff_en,
    output logic signed [OUT_W-1:0] DAC_I,
    output logic signed [OUT_W-1:0] DAC_Q,
    output logic                    iq_valid,
    output logic                    sym_start,
    output logic                    frame_end
);

    localparam int                      CW         = $clog2(SPS);
    localparam logic [CW-1:0]           C_CNT_LAST = CW'(SPS - 1);
    localparam int                      C_D_INT    = (AMP * 181 + 128) >>> 8;
    localparam logic signed [OUT_W-1:0] C_AMP      = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0] C_DIAG     = OUT_W'(C_D_INT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              ref_q, ref_d;
    logic                    first_q, first_d;
    logic                    diff_q, diff_d;
    logic                    last_q, last_d;
    logic signed [OUT_W-1:0] dac_i_q, dac_i_d;
    logic signed [OUT_W-1:0] dac_q_q, dac_q_d;

    logic                    sym_end, accept, frame_done;
    logic                    first_eff, diff_eff;
    logic [2:0]              ref_eff, k, idx;
    logic signed [OUT_W-1:0] pt_i, pt_q;
    logic                    tdata_unused;

    assign tdata_unused = |data_tdata[7:3];

    always_comb begin
        sym_end     = (state_q == S_EMIT) && (cnt_q == C_CNT_LAST);
        data_tready = (state_q == S_IDLE) || sym_end;
        accept      = data_tvalid && data_tready;
        // A beat accepted right as a tlast symbol ends already belongs to the new frame.
        frame_done  = sym_end && last_q;
        first_eff   = first_q || frame_done;
        ref_eff     = frame_done ? 3'd0 : ref_q;
        diff_eff    = first_eff ? diff_en : diff_q;

        case (data_tuser)
            2'd0: begin
                case (data_tdata[1:0])
                    2'b00:   k = 3'd1;
                    2'b01:   k = 3'd3;
                    2'b11:   k = 3'd5;
                    default: k = 3'd7;
                endcase
            end
            2'd1:    k = data_tdata[1] ? 3'd4 : 3'd0;
            2'd2: begin
                case (data_tdata[2:0])
                    3'b000:  k = 3'd0;
                    3'b001:  k = 3'd1;
                    3'b011:  k = 3'd2;
                    3'b010:  k = 3'd3;
                    3'b110:  k = 3'd4;
                    3'b111:  k = 3'd5;
                    3'b101:  k = 3'd6;
                    default: k = 3'd7;
                endcase
            end
            default: k = 3'd0;
        endcase

        idx = diff_eff ? (ref_eff + k) : k;

        case (idx)
            3'd0:    begin pt_i =  C_AMP;  pt_q = '0;      end
            3'd1:    begin pt_i =  C_DIAG; pt_q =  C_DIAG; end
            3'd2:    begin pt_i = '0;      pt_q =  C_AMP;  end
            3'd3:    begin pt_i = -C_DIAG; pt_q =  C_DIAG; end
            3'd4:    begin pt_i = -C_AMP;  pt_q = '0;      end
            3'd5:    begin pt_i = -C_DIAG; pt_q = -C_DIAG; end
            3'd6:    begin pt_i = '0;      pt_q = -C_AMP;  end
            default: begin pt_i =  C_DIAG; pt_q = -C_DIAG; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_eff;
        first_d = first_eff;
        diff_d  = diff_q;
        last_d  = last_q;
        dac_i_d = dac_i_q;
        dac_q_d = dac_q_q;

        if (state_q == S_EMIT && !sym_end) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (accept) begin
            state_d = S_EMIT;
            cnt_d   = '0;
            last_d  = data_tlast;
            first_d = 1'b0;
            diff_d  = diff_eff;
            if (data_tuser == 2'd3) begin
                dac_i_d = '0;
                dac_q_d = '0;
            end else begin
                dac_i_d = pt_i;
                dac_q_d = pt_q;
                if (diff_eff) begin
                    ref_d = idx;
                end
            end
        end else if (sym_end) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dac_i_d = '0;
            dac_q_d = '0;
        end
    end

    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ref_q   <= 3'd0;
            first_q <= 1'b1;
            diff_q  <= 1'b0;
            last_q  <= 1'b0;
            dac_i_q <= '0;
            dac_q_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            first_q <= first_d;
            diff_q  <= diff_d;
            last_q  <= last_d;
            dac_i_q <= dac_i_d;
            dac_q_q <= dac_q_d;
        end
    end

    assign DAC_I     = dac_i_q;
    assign DAC_Q     = dac_q_q;
    assign iq_valid  = (state_q == S_EMIT);
    assign sym_start = iq_valid && (cnt_q == '0);
    assign frame_end = frame_done;

endmodule
`default_nettype wire

// File: tb/tb_psk_symbol_modulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_psk_symbol_modulator: scoreboard bench for psk_symbol_modulator          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_psk_symbol_modulator;

    localparam int OUT_W = 12;
    localparam int SPS   = 16;
    localparam int AMP   = 1024;

    logic                    clk_16M384;
    logic                    rst_n_16M384;
    logic [7:0]              data_tdata;
    logic                    data_tvalid;
    logic                    data_tready;
    logic                    data_tlast;
    logic [1:0]              data_tuser;
    logic                    diff_en;
    logic signed [OUT_W-1:0] DAC_I;
    logic signed [OUT_W-1:0] DAC_Q;
    logic                    iq_valid;
    logic                    sym_start;
    logic                    frame_end;

    psk_symbol_modulator #(.OUT_W(OUT_W), .SPS(SPS), .AMP(AMP)) u_dut (
        .clk_16M384   (clk_16M384),
        .rst_n_16M384 (rst_n_16M384),
        .data_tdata   (data_tdata),
        .data_tvalid  (data_tvalid),
        .data_tready  (data_tready),
        .data_tlast   (data_tlast),
        .data_tuser   (data_tuser),
        .diff_en      (diff_en),
        .DAC_I        (DAC_I),
        .DAC_Q        (DAC_Q),
        .iq_valid     (iq_valid),
        .sym_start    (sym_start),
        .frame_end    (frame_end)
    );

    initial clk_16M384 = 1'b0;
    always #5 clk_16M384 = ~clk_16M384;

    typedef struct {
        int i;
        int q;
        bit last;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   rem;
    int   n_vec;
    int   n_err;

    // Constellation: index k sits at angle k*45 degrees, diagonal = 724.
    int pt_i [8] = '{1024,  724,    0, -724, -1024, -724,     0,  724};
    int pt_q [8] = '{   0,  724, 1024,  724,     0, -724, -1024, -724};

    int  ref_m;
    bit  first_m;
    bit  diff_m;

    task automatic check_val(input string tag, input int got, input int exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp_v, $time);
        end
    endtask

    function automatic int gray_dec(input int g);
        return g ^ (g >> 1) ^ (g >> 2);
    endfunction

    function automatic int phase_of(input int sym, input int mode);
        case (mode)
            0:       return 2 * gray_dec(sym & 3) + 1;
            1:       return 4 * ((sym >> 1) & 1);
            2:       return gray_dec(sym & 7);
            default: return 0;
        endcase
    endfunction

    task automatic send(input int sym, input int mode, input bit last, input bit diff);
        int   k;
        int   idx;
        exp_t e;
        data_tdata  = 8'(sym);
        data_tuser  = 2'(mode);
        data_tlast  = last;
        diff_en     = diff;
        data_tvalid = 1'b1;
        for (int n = 0; !data_tready; n++) begin
            if (n > 100) begin
                check_val("tready_timeout", 0, 1);
                data_tvalid = 1'b0;
                return;
            end
            @(negedge clk_16M384);
        end
        @(posedge clk_16M384);
        if (first_m) diff_m = diff;
        if (mode == 3) begin
            e = '{0, 0, last};
        end else begin
            k   = phase_of(sym, mode);
            idx = diff_m ? ((ref_m + k) % 8) : k;
            if (diff_m) ref_m = idx;
            e = '{pt_i[idx], pt_q[idx], last};
        end
        first_m = 1'b0;
        if (last) begin
            ref_m   = 0;
            first_m = 1'b1;
        end
        sb.push_back(e);
        @(negedge clk_16M384);
    endtask

    task automatic idle(input int n);
        data_tvalid = 1'b0;
        repeat (n) @(negedge clk_16M384);
    endtask

    always @(negedge clk_16M384) begin
        if (!rst_n_16M384) begin
            rem = 0;
            sb.delete();
        end else begin
            if (rem == 0 && sb.size() > 0) begin
                cur = sb.pop_front();
                rem = SPS;
            end
            if (rem == 0) begin
                check_val("idle_valid", int'(iq_valid), 0);
                check_val("idle_dac_i", int'(DAC_I), 0);
                check_val("idle_dac_q", int'(DAC_Q), 0);
                check_val("idle_tready", int'(data_tready), 1);
            end else begin
                check_val("iq_valid", int'(iq_valid), 1);
                check_val("dac_i", int'(DAC_I), cur.i);
                check_val("dac_q", int'(DAC_Q), cur.q);
                check_val("sym_start", int'(sym_start), int'(rem == SPS));
                check_val("frame_end", int'(frame_end), int'(rem == 1 && cur.last));
                check_val("tready", int'(data_tready), int'(rem == 1));
                rem--;
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rem = 0;
        ref_m = 0;
        first_m = 1'b1;
        diff_m = 1'b0;
        rst_n_16M384 = 1'b0;
        data_tdata = '0;
        data_tvalid = 1'b0;
        data_tlast = 1'b0;
        data_tuser = '0;
        diff_en = 1'b0;
        repeat (3) @(negedge clk_16M384);
        check_val("rst_dac_i", int'(DAC_I), 0);
        check_val("rst_dac_q", int'(DAC_Q), 0);
        check_val("rst_valid", int'(iq_valid), 0);
        check_val("rst_sym_start", int'(sym_start), 0);
        check_val("rst_frame_end", int'(frame_end), 0);
        check_val("rst_tready", int'(data_tready), 1);
        @(posedge clk_16M384);
        #2 rst_n_16M384 = 1'b1;
        @(negedge clk_16M384);

        // BPSK 0,1,0,1,1 back-to-back, absolute
        send(0, 1, 0, 0); send(2, 1, 0, 0); send(0, 1, 0, 0);
        send(2, 1, 0, 0); send(2, 1, 1, 0);
        // QPSK 00,01,10,11 absolute
        send(0, 0, 0, 0); send(1, 0, 0, 0); send(2, 0, 0, 0); send(3, 0, 1, 0);
        // 8PSK differential 001,001,011 then a fresh frame 001
        send(1, 2, 0, 1); send(1, 2, 0, 1); send(3, 2, 1, 1);
        send(1, 2, 1, 1);
        // QPSK 10 then BPSK 1 with no gap
        send(2, 0, 0, 0); send(2, 1, 1, 0);
        idle(40);
        // Reserved mode inside a differential frame leaves the reference alone
        send(1, 2, 0, 1); send(0, 3, 0, 1); send(1, 2, 1, 1);
        idle(20);

        // Reset asserted on sample 7 of a differential symbol
        send(3, 2, 0, 1);
        data_tvalid = 1'b0;
        repeat (7) @(posedge clk_16M384);
        #2 rst_n_16M384 = 1'b0;
        #1;
        check_val("async_rst_dac_i", int'(DAC_I), 0);
        check_val("async_rst_dac_q", int'(DAC_Q), 0);
        check_val("async_rst_valid", int'(iq_valid), 0);
        check_val("async_rst_tready", int'(data_tready), 1);
        ref_m = 0;
        first_m = 1'b1;
        diff_m = 1'b0;
        repeat (2) @(posedge clk_16M384);
        #2 rst_n_16M384 = 1'b1;
        @(negedge clk_16M384);
        send(1, 2, 1, 1);
        idle(SPS + 8);

        check_val("scoreboard_drained", sb.size() + rem, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
